hazard_scoreboard: RTL and testbench

//  Stall/forwarding controller for the 5-stage P5 pipeline, fed each cycle by the D-stage decoder
//  (TuseRs/TuseRt/Tnew/RegWrite). Keeps a shadow pipeline of destination register, Tnew and

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Stall/forwarding controller for the 5-stage pipeline: shadows destination, Tnew and sources
// for E/M/W, and derives the D-stage stall, operand forwarding selects and a stall counter.
module hazard_scoreboard #(
  parameter int RA_W  = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  D_Rs,
  input  logic [RA_W-1:0]  D_Rt,
  input  logic [RA_W-1:0]  D_A3,
  input  logic             D_RegWrite,
  input  logic [T_W-1:0]   D_TuseRs,
  input  logic [T_W-1:0]   D_TuseRt,
  input  logic [T_W-1:0]   D_Tnew,
  output logic             Stall,
  output logic [1:0]       D_FwdRs,
  output logic [1:0]       D_FwdRt,
  output logic [1:0]       E_FwdRs,
  output logic [1:0]       E_FwdRt,
  output logic [1:0]       M_FwdRt,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [T_W-1:0] TuseNone = '1;

  logic [RA_W-1:0]  eA3Reg, eRsReg, eRtReg;
  logic [T_W-1:0]   eTnewReg;
  logic [RA_W-1:0]  mA3Reg, mRtReg;
  logic [T_W-1:0]   mTnewReg;
  logic [RA_W-1:0]  wA3Reg;
  logic [CNT_W-1:0] stallCountReg;

  logic [1:0]       hazard;
  logic [1:0][1:0]  dFwd;
  logic [1:0][1:0]  eFwd;
  logic [T_W-1:0]   mTnewNext;

  // Operand 0 is rs, operand 1 is rt, for both the D-stage and E-stage checks.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : opGen
      logic [RA_W-1:0] dSrc;
      logic [T_W-1:0]  dTuse;
      logic [RA_W-1:0] eSrc;
      logic            dEMatch, dMMatch, dWMatch;
      logic            eMMatch, eWMatch;

      assign dSrc  = (gi == 0) ? D_Rs : D_Rt;
      assign dTuse = (gi == 0) ? D_TuseRs : D_TuseRt;
      assign eSrc  = (gi == 0) ? eRsReg : eRtReg;

      assign dEMatch = (dSrc != '0) && (eA3Reg == dSrc);
      assign dMMatch = (dSrc != '0) && (mA3Reg == dSrc);
      assign dWMatch = (dSrc != '0) && (wA3Reg == dSrc);

      assign hazard[gi] = (dTuse != TuseNone) &&
                          ((dEMatch && (eTnewReg > dTuse)) || (dMMatch && (mTnewReg > dTuse)));

      // A younger match whose value is not ready yet hides older stages; the stall covers it.
      assign dFwd[gi] = dEMatch ? ((eTnewReg == '0) ? 2'd1 : 2'd0) :
                        dMMatch ? ((mTnewReg == '0) ? 2'd2 : 2'd0) :
                        dWMatch ? 2'd3 : 2'd0;

      assign eMMatch = (eSrc != '0) && (mA3Reg == eSrc);
      assign eWMatch = (eSrc != '0) && (wA3Reg == eSrc);

      assign eFwd[gi] = (eMMatch && (mTnewReg == '0)) ? 2'd2 :
                        eWMatch ? 2'd3 : 2'd0;
    end
  endgenerate

  assign Stall      = |hazard;
  assign D_FwdRs    = dFwd[0];
  assign D_FwdRt    = dFwd[1];
  assign E_FwdRs    = eFwd[0];
  assign E_FwdRt    = eFwd[1];
  assign M_FwdRt    = ((mRtReg != '0) && (wA3Reg == mRtReg)) ? 2'd3 : 2'd0;
  assign StallCount = stallCountReg;

  assign mTnewNext = (eTnewReg == '0) ? '0 : eTnewReg - T_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      eA3Reg        <= '0;
      eTnewReg      <= '0;
      eRsReg        <= '0;
      eRtReg        <= '0;
      mA3Reg        <= '0;
      mTnewReg      <= '0;
      mRtReg        <= '0;
      wA3Reg        <= '0;
      stallCountReg <= '0;
    end else begin
      if (Stall) begin
        eA3Reg   <= '0;
        eTnewReg <= '0;
        eRsReg   <= '0;
        eRtReg   <= '0;
      end else begin
        eA3Reg   <= D_RegWrite ? D_A3 : '0;
        eTnewReg <= D_Tnew;
        eRsReg   <= D_Rs;
        eRtReg   <= D_Rt;
      end
      mA3Reg   <= eA3Reg;
      mTnewReg <= mTnewNext;
      mRtReg   <= eRtReg;
      wA3Reg   <= mA3Reg;
      if (Stall && !(&stallCountReg)) begin
        stallCountReg <= stallCountReg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: instruction sequences with hand-derived stall,
// forwarding and stall-count expectations checked each cycle.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  D_Rs, D_Rt, D_A3;
  logic        D_RegWrite;
  logic [1:0]  D_TuseRs, D_TuseRt, D_Tnew;
  logic        Stall;
  logic [1:0]  D_FwdRs, D_FwdRt, E_FwdRs, E_FwdRt, M_FwdRt;
  logic [31:0] StallCount;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .D_Rs      (D_Rs),
    .D_Rt      (D_Rt),
    .D_A3      (D_A3),
    .D_RegWrite(D_RegWrite),
    .D_TuseRs  (D_TuseRs),
    .D_TuseRt  (D_TuseRt),
    .D_Tnew    (D_Tnew),
    .Stall     (Stall),
    .D_FwdRs   (D_FwdRs),
    .D_FwdRt   (D_FwdRt),
    .E_FwdRs   (E_FwdRs),
    .E_FwdRt   (E_FwdRt),
    .M_FwdRt   (M_FwdRt),
    .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction in D: rs, rt, a3, regWrite, tuseRs, tuseRt, tnew.
  task automatic issue(input string name, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] a3, input logic rw, input logic [1:0] tRs,
                       input logic [1:0] tRt, input logic [1:0] tn);
    D_Rs = rs; D_Rt = rt; D_A3 = a3; D_RegWrite = rw;
    D_TuseRs = tRs; D_TuseRt = tRt; D_Tnew = tn;
    $display("t=%0t issue %s rs=%0d rt=%0d a3=%0d rw=%0d tuse=%0d/%0d tnew=%0d",
             $time, name, rs, rt, a3, rw, tRs, tRt, tn);
  endtask

  task automatic issueNop();
    issue("nop", 5'd0, 5'd0, 5'd0, 1'b0, 2'd3, 2'd3, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    issueNop();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    // Garbage in D during reset must be discarded.
    issue("junk", 5'd7, 5'd7, 5'd7, 1'b1, 2'd0, 2'd0, 2'd2);
    tick();
    tick();
    reset = 1'b0;
    issueNop();
    @(negedge clk);
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", Stall); end
    total++;
    if (StallCount !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", StallCount); end
    total++;
    if ({D_FwdRs, D_FwdRt, E_FwdRs, E_FwdRt, M_FwdRt} !== 10'd0) begin
      bad++;
      $display("FAIL reset_fwd: got %b want 0000000000",
               {D_FwdRs, D_FwdRt, E_FwdRs, E_FwdRt, M_FwdRt});
    end
    tick();
    total++;
    if ({Stall, E_FwdRs, E_FwdRt, M_FwdRt} !== 7'd0) begin
      bad++;
      $display("FAIL reset_discard: got %b want 0000000", {Stall, E_FwdRs, E_FwdRt, M_FwdRt});
    end
  endtask

  task automatic test_load_use();
    doReset();
    issue("lw $1", 5'd2, 5'd1, 5'd1, 1'b1, 2'd1, 2'd3, 2'd2);
    tick();
    issue("add $3,$1,$2", 5'd1, 5'd2, 5'd3, 1'b1, 2'd1, 2'd1, 2'd1);
    @(negedge clk);
    total++;
    if (Stall !== 1'b1) begin bad++; $display("FAIL lu_stall1: got %0b want 1", Stall); end
    tick();
    @(negedge clk);
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL lu_stall2: got %0b want 0", Stall); end
    total++;
    if (D_FwdRs !== 2'd0) begin bad++; $display("FAIL lu_dfwdrs: got %0d want 0", D_FwdRs); end
    total++;
    if (StallCount !== 32'd1) begin bad++; $display("FAIL lu_count: got %0d want 1", StallCount); end
    tick();
    issueNop();
    @(negedge clk);
    total++;
    if (E_FwdRs !== 2'd3) begin bad++; $display("FAIL lu_efwdrs: got %0d want 3", E_FwdRs); end
    total++;
    if (E_FwdRt !== 2'd0) begin bad++; $display("FAIL lu_efwdrt: got %0d want 0", E_FwdRt); end
  endtask

  task automatic test_load_branch();
    doReset();
    issue("lw $1", 5'd2, 5'd1, 5'd1, 1'b1, 2'd1, 2'd3, 2'd2);
    tick();
    issue("beq $1,$0", 5'd1, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    total++;
    if (Stall !== 1'b1) begin bad++; $display("FAIL lb_stall1: got %0b want 1", Stall); end
    tick();
    @(negedge clk);
    total++;
    if (Stall !== 1'b1) begin bad++; $display("FAIL lb_stall2: got %0b want 1", Stall); end
    tick();
    @(negedge clk);
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL lb_stall3: got %0b want 0", Stall); end
    total++;
    if (D_FwdRs !== 2'd3) begin bad++; $display("FAIL lb_dfwdrs: got %0d want 3", D_FwdRs); end
    total++;
    if (D_FwdRt !== 2'd0) begin bad++; $display("FAIL lb_dfwdrt: got %0d want 0", D_FwdRt); end
    total++;
    if (StallCount !== 32'd2) begin bad++; $display("FAIL lb_count: got %0d want 2", StallCount); end
  endtask

  task automatic test_alu_branch();
    doReset();
    issue("ori $2", 5'd0, 5'd2, 5'd2, 1'b1, 2'd1, 2'd3, 2'd1);
    tick();
    issue("beq $2,$2", 5'd2, 5'd2, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    total++;
    if (Stall !== 1'b1) begin bad++; $display("FAIL ab_stall1: got %0b want 1", Stall); end
    tick();
    @(negedge clk);
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL ab_stall2: got %0b want 0", Stall); end
    total++;
    if ({D_FwdRs, D_FwdRt} !== 4'b1010) begin
      bad++;
      $display("FAIL ab_dfwd: got rs=%0d rt=%0d want rs=2 rt=2", D_FwdRs, D_FwdRt);
    end
    total++;
    if (StallCount !== 32'd1) begin bad++; $display("FAIL ab_count: got %0d want 1", StallCount); end
  endtask

  task automatic test_jal_jr();
    doReset();
    issue("jal", 5'd0, 5'd0, 5'd31, 1'b1, 2'd3, 2'd3, 2'd0);
    tick();
    issue("jr $31", 5'd31, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd0);
    @(negedge clk);
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL jr_stall: got %0b want 0", Stall); end
    total++;
    if (D_FwdRs !== 2'd1) begin bad++; $display("FAIL jr_dfwdrs: got %0d want 1", D_FwdRs); end
    total++;
    if (StallCount !== 32'd0) begin bad++; $display("FAIL jr_count: got %0d want 0", StallCount); end
  endtask

  task automatic test_zero_and_unused();
    doReset();
    issue("lui $0", 5'd0, 5'd0, 5'd0, 1'b1, 2'd3, 2'd3, 2'd1);
    tick();
    issue("add $1,$0,$0", 5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd1, 2'd1);
    @(negedge clk);
    total++;
    if ({Stall, D_FwdRs, D_FwdRt} !== 5'd0) begin
      bad++;
      $display("FAIL zr_d: got stall=%0b rs=%0d rt=%0d want 0 0 0", Stall, D_FwdRs, D_FwdRt);
    end
    tick();
    issue("lw $5", 5'd6, 5'd5, 5'd5, 1'b1, 2'd1, 2'd3, 2'd2);
    @(negedge clk);
    total++;
    if ({Stall, E_FwdRs, E_FwdRt} !== 5'd0) begin
      bad++;
      $display("FAIL zr_e: got stall=%0b ers=%0d ert=%0d want 0 0 0", Stall, E_FwdRs, E_FwdRt);
    end
    tick();
    issue("unused $5,$5", 5'd5, 5'd5, 5'd0, 1'b0, 2'd3, 2'd3, 2'd0);
    @(negedge clk);
    total++;
    if ({Stall, D_FwdRs, D_FwdRt} !== 5'd0) begin
      bad++;
      $display("FAIL un_d: got stall=%0b rs=%0d rt=%0d want 0 0 0", Stall, D_FwdRs, D_FwdRt);
    end
    total++;
    if (StallCount !== 32'd0) begin bad++; $display("FAIL un_count: got %0d want 0", StallCount); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    issue("lw $1", 5'd2, 5'd1, 5'd1, 1'b1, 2'd1, 2'd3, 2'd2);
    tick();
    issue("beq $1,$0", 5'd1, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    total++;
    if (Stall !== 1'b1) begin bad++; $display("FAIL rm_stall1: got %0b want 1", Stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL rm_stall2: got %0b want 0", Stall); end
    total++;
    if (StallCount !== 32'd0) begin bad++; $display("FAIL rm_count: got %0d want 0", StallCount); end
    total++;
    if ({D_FwdRs, D_FwdRt, E_FwdRs, E_FwdRt, M_FwdRt} !== 10'd0) begin
      bad++;
      $display("FAIL rm_fwd: got %b want 0000000000",
               {D_FwdRs, D_FwdRt, E_FwdRs, E_FwdRt, M_FwdRt});
    end
  endtask

  task automatic test_store_fwd();
    doReset();
    issue("add $1,$2,$3", 5'd2, 5'd3, 5'd1, 1'b1, 2'd1, 2'd1, 2'd1);
    tick();
    issue("sw $1,0($4)", 5'd4, 5'd1, 5'd0, 1'b0, 2'd1, 2'd2, 2'd0);
    @(negedge clk);
    total++;
    if ({Stall, D_FwdRt} !== 3'd0) begin
      bad++;
      $display("FAIL sw_d: got stall=%0b rt=%0d want 0 0", Stall, D_FwdRt);
    end
    tick();
    issueNop();
    @(negedge clk);
    total++;
    if (E_FwdRt !== 2'd2) begin bad++; $display("FAIL sw_efwdrt: got %0d want 2", E_FwdRt); end
    tick();
    @(negedge clk);
    total++;
    if (M_FwdRt !== 2'd3) begin bad++; $display("FAIL sw_mfwdrt: got %0d want 3", M_FwdRt); end
    tick();
    @(negedge clk);
    total++;
    if (M_FwdRt !== 2'd0) begin bad++; $display("FAIL sw_mfwdrt_clr: got %0d want 0", M_FwdRt); end
  endtask

  initial begin
    reset = 1'b1;
    issueNop();
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_jal_jr();
    test_zero_and_unused();
    test_reset_mid_stall();
    test_store_fwd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
